// File: rtl/qos_wrr_arbiter_pkg.sv
// Shared types for the QoS weighted round-robin arbiter.
// State encoding, class count and one-hot helper.
package qos_arb_pkg;

  localparam int NCLASS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SERVE
  } state_e;

  function automatic logic [NCLASS-1:0] onehot(
    input logic [1:0] idx
  );
    logic [NCLASS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/qos_wrr_arbiter_if.sv
// Class-FIFO side of the arbiter: empty flags and
// back-pressure in, grant/pop/busy out.
interface qos_wrr_arbiter_if;
  import qos_arb_pkg::*;

  logic [NCLASS-1:0] EMPTY;
  logic              PAUSE;
  logic [NCLASS-1:0] GRAND;
  logic              POPDATOCF;
  logic              BUSY;

  modport master (
    input  EMPTY,
    input  PAUSE,
    output GRAND,
    output POPDATOCF,
    output BUSY
  );

  modport slave (
    output EMPTY,
    output PAUSE,
    input  GRAND,
    input  POPDATOCF,
    input  BUSY
  );

endinterface

// File: rtl/qos_wrr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of elig_i
// searching upward from ptr_i, wrapping modulo NCLASS.
module rr_pick
  import qos_arb_pkg::*;
(
  input  logic [NCLASS-1:0] elig_i,
  input  logic [1:0]        ptr_i,
  output logic              hit_o,
  output logic [1:0]        idx_o
);

  logic [1:0] k;

  // Scan farthest offset first so the nearest hit wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = ptr_i;
    k     = ptr_i;
    for (int j = NCLASS - 1; j >= 0; j--) begin
      k = ptr_i + 2'(j);
      if (elig_i[k]) begin
        hit_o = 1'b1;
        idx_o = k;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_arbiter.sv
// Weighted round-robin scheduler draining four class
// FIFOs into the principal FIFO in weighted bursts.
module qos_wrr_arbiter
  import qos_arb_pkg::*;
#(
  parameter int WEIGHT_W = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic [WEIGHT_W-1:0] WEIGHT0,
  input  logic [WEIGHT_W-1:0] WEIGHT1,
  input  logic [WEIGHT_W-1:0] WEIGHT2,
  input  logic [WEIGHT_W-1:0] WEIGHT3,
  qos_wrr_arbiter_if.master   bus
);

  state_e              state_q;
  logic [NCLASS-1:0]   grand_q;
  logic [1:0]          ptr_q;
  logic [WEIGHT_W-1:0] credit_q;

  logic [WEIGHT_W-1:0] weight [NCLASS];
  logic [NCLASS-1:0]   elig;
  logic                hit;
  logic [1:0]          idx;
  logic                gnt_empty;
  logic                pop;

  assign weight[0] = WEIGHT0;
  assign weight[1] = WEIGHT1;
  assign weight[2] = WEIGHT2;
  assign weight[3] = WEIGHT3;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCLASS; i++) begin
      elig[i] = ~bus.EMPTY[i] & (weight[i] != '0);
    end
  end

  rr_pick u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .hit_o  (hit),
    .idx_o  (idx)
  );

  assign gnt_empty = |(grand_q & bus.EMPTY);

  assign pop = (state_q == SERVE) & ~gnt_empty
             & ~bus.PAUSE & ENABLE & ~RESET;

  assign bus.POPDATOCF = pop;
  assign bus.GRAND     = grand_q;
  assign bus.BUSY      = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      grand_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else if (!ENABLE) begin
      state_q  <= IDLE;
      grand_q  <= '0;
      credit_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          grand_q <= '0;
          if (hit) state_q <= SELECT;
        end
        SELECT: begin
          if (hit) begin
            grand_q  <= onehot(idx);
            credit_q <= weight[idx];
            ptr_q    <= idx + 2'd1;
            state_q  <= SERVE;
          end else begin
            grand_q <= '0;
            state_q <= IDLE;
          end
        end
        SERVE: begin
          // Empty granted FIFO releases the burst early.
          if (gnt_empty) begin
            grand_q <= '0;
            state_q <= SELECT;
          end else if (pop) begin
            credit_q <= credit_q - WEIGHT_W'(1);
            if (credit_q == WEIGHT_W'(1)) begin
              grand_q <= '0;
              state_q <= SELECT;
            end
          end
        end
        default: begin
          grand_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Self-checking bench for qos_wrr_arbiter: burst-level
// scheduling model plus directed literal expectations.
module tb_qos_wrr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pause;
  logic [3:0] w0, w1, w2, w3;

  always #5 clk = ~clk;

  qos_wrr_arbiter_if ifc ();

  qos_wrr_arbiter #(.WEIGHT_W(4)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .ENABLE  (en),
    .WEIGHT0 (w0),
    .WEIGHT1 (w1),
    .WEIGHT2 (w2),
    .WEIGHT3 (w3),
    .bus     (ifc)
  );

  int cnt [4];

  always_comb begin
    for (int i = 0; i < 4; i++) ifc.EMPTY[i] = (cnt[i] == 0);
  end
  assign ifc.PAUSE = pause;

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  int popq [$];
  int popcyc [$];
  bit last_pop;

  // model: 0 idle, 1 choosing, 2 bursting
  int m_phase = 0;
  int m_cls   = -1;
  int m_left  = 0;
  int m_start = 0;

  bit es [4];
  int ws [4];
  bit sr, se, sp;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int first_elig(int start);
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (start + j) % 4;
      if (!es[k] && ws[k] != 0) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    int k;
    if (sr) begin
      m_phase = 0; m_cls = -1; m_left = 0; m_start = 0;
    end else if (!se) begin
      m_phase = 0; m_cls = -1; m_left = 0;
    end else begin
      case (m_phase)
        0: if (first_elig(m_start) >= 0) m_phase = 1;
        1: begin
          k = first_elig(m_start);
          if (k >= 0) begin
            m_cls = k; m_left = ws[k];
            m_start = (k + 1) % 4; m_phase = 2;
          end else m_phase = 0;
        end
        default: begin
          if (es[m_cls]) begin
            m_phase = 1; m_cls = -1;
          end else if (!sp) begin
            m_left--;
            if (m_left == 0) begin
              m_phase = 1; m_cls = -1;
            end
          end
        end
      endcase
    end
  endtask

  task automatic cyc();
    logic [3:0] eg, g;
    bit ep, p;
    int k;
    @(negedge clk);
    ncyc++;
    eg = (m_phase == 2) ? 4'(1 << m_cls) : 4'd0;
    ep = (m_phase == 2) && (cnt[m_cls] != 0)
         && !pause && en && !rst;
    chk("grand", int'(ifc.GRAND), int'(eg));
    chk("pop", int'(ifc.POPDATOCF), int'(ep));
    chk("busy", int'(ifc.BUSY), int'(m_phase != 0));
    chk("ptr", int'(dut.ptr_q), m_start);
    if (m_phase == 2) chk("credit", int'(dut.credit_q), m_left);
    p = ifc.POPDATOCF;
    g = ifc.GRAND;
    last_pop = p;
    for (int i = 0; i < 4; i++) es[i] = (cnt[i] == 0);
    ws[0] = int'(w0); ws[1] = int'(w1);
    ws[2] = int'(w2); ws[3] = int'(w3);
    sr = rst; se = en; sp = pause;
    @(posedge clk);
    model_step();
    #1;
    if (p) begin
      k = -1;
      for (int i = 0; i < 4; i++) if (g == 4'(1 << i)) k = i;
      if (k >= 0 && cnt[k] > 0) cnt[k]--;
      popq.push_back(k);
      popcyc.push_back(ncyc);
    end
  endtask

  int exp2 [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
  int guard;

  initial begin
    rst = 1'b1; en = 1'b0; pause = 1'b0;
    w0 = 4'd0; w1 = 4'd0; w2 = 4'd0; w3 = 4'd0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc();
    chk("rst_grand", int'(ifc.GRAND), 0);
    chk("rst_busy", int'(ifc.BUSY), 0);
    chk("rst_ptr", int'(dut.ptr_q), 0);

    // all empty: nothing happens
    rst = 1'b0; en = 1'b1;
    w0 = 4'd2; w1 = 4'd2; w2 = 4'd2; w3 = 4'd2;
    repeat (8) cyc();
    chk("idle_grand", int'(ifc.GRAND), 0);
    chk("idle_busy", int'(ifc.BUSY), 0);

    // weighted rotation 3,1,2,1
    w0 = 4'd3; w1 = 4'd1; w2 = 4'd2; w3 = 4'd1;
    for (int i = 0; i < 4; i++) cnt[i] = 10;
    popq.delete(); popcyc.delete();
    guard = 0;
    while (popq.size() < 10 && guard < 60) begin
      cyc(); guard++;
    end
    chk("wrr_count", popq.size(), 10);
    if (popq.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk("wrr_seq", popq[i], exp2[i]);
      chk("wrr_span", popcyc[9] - popcyc[0] + 1, 14);
    end
    en = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    cyc();
    chk("dis_ptr", int'(dut.ptr_q), 1);

    // class 1 alone, 2 words, weight 5
    w0 = 4'd3; w1 = 4'd5; w2 = 4'd2; w3 = 4'd1;
    cnt[1] = 2;
    en = 1'b1;
    popq.delete();
    repeat (8) cyc();
    chk("early_count", popq.size(), 2);
    if (popq.size() == 2) begin
      chk("early_cls0", popq[0], 1);
      chk("early_cls1", popq[1], 1);
    end
    chk("early_ptr", int'(dut.ptr_q), 2);
    chk("early_busy", int'(ifc.BUSY), 0);

    // pause mid-burst on class 2, weight 4
    w0 = 4'd1; w1 = 4'd1; w2 = 4'd4; w3 = 4'd1;
    cnt[2] = 10;
    popq.delete();
    guard = 0;
    while (popq.size() < 2 && guard < 20) begin
      cyc(); guard++;
    end
    chk("pause_pre", popq.size(), 2);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("pause_grand", int'(ifc.GRAND), 4);
      chk("pause_credit", int'(dut.credit_q), 2);
    end
    chk("pause_nopop", popq.size(), 2);
    pause = 1'b0;
    cyc(); cyc();
    chk("pause_done", popq.size(), 4);
    chk("pause_bubble", int'(ifc.GRAND), 0);
    chk("pause_sel", int'(ifc.BUSY), 1);
    en = 1'b0;
    cyc();
    cnt[2] = 0;

    // weight 0 blocks a non-empty class
    w0 = 4'd0; w1 = 4'd2; w2 = 4'd2; w3 = 4'd2;
    cnt[0] = 5;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("w0_busy", int'(ifc.BUSY), 0);
    end
    chk("w0_cnt", cnt[0], 5);
    cnt[0] = 0;

    // reset on the second pop of a weight-4 burst
    w0 = 4'd4; w1 = 4'd4; w2 = 4'd4; w3 = 4'd4;
    cnt[3] = 10;
    popq.delete();
    guard = 0;
    while (popq.size() < 1 && guard < 20) begin
      cyc(); guard++;
    end
    chk("rst_first", popq.size(), 1);
    rst = 1'b1;
    cyc();
    chk("rst_pop", int'(last_pop), 0);
    chk("rst2_grand", int'(ifc.GRAND), 0);
    chk("rst2_busy", int'(ifc.BUSY), 0);
    chk("rst2_ptr", int'(dut.ptr_q), 0);
    rst = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
